// File: rtl/muldiv_pkg.sv
// Shared op codes, sequencer state encoding and default datapath width for the
// HI/LO multiply/divide sequencer.
package muldiv_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_WB   = 3'd4
    } state_t;

endpackage

// File: rtl/muldiv_seq_neg_if.sv
// Conditional two's-complement negate; used for operand magnitudes and for
// restoring the sign of results.
module neg_if #(
    parameter int W = 32
) (
    input  logic         neg,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle HI/LO sequencer: iterative shift-add multiply, restoring divide,
// and MTHI/MTLO, finishing with a single HI/LO write pulse.
//
//   state | meaning
//   IDLE  | waiting for start; MTHI/MTLO/div-by-zero go straight to WB
//   MUL   | one multiplier bit per cycle, LSB first; terminal cycle at cnt == ITER
//   DIV   | one restoring step per cycle, MSB first; terminal cycle at cnt == ITER
//   FIX   | apply result signs, load write_hi/write_lo
//   WB    | hi_lo_we/done high for exactly one cycle
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic [WIDTH-1:0] hi_cur,
    input  logic [WIDTH-1:0] lo_cur,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             hi_lo_we,
    output logic [WIDTH-1:0] write_hi,
    output logic [WIDTH-1:0] write_lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(ITER + 1);

    state_t               state, state_nx;
    logic                 is_mul, is_mul_nx;
    logic                 sign, sign_nx;
    logic                 q_sign, q_sign_nx;
    logic                 r_sign, r_sign_nx;
    logic [WIDTH-1:0]     op_a, op_a_nx;
    logic [WIDTH-1:0]     op_b, op_b_nx;
    logic [2*WIDTH-1:0]   acc, acc_nx;
    logic [CW-1:0]        cnt, cnt_nx;

    logic                 busy_nx, done_nx, hi_lo_we_nx, div_by_zero_nx;
    logic [WIDTH-1:0]     write_hi_nx, write_lo_nx;

    logic                 signed_op;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH+1:0]     div_diff;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix, rem_fix;

    assign signed_op = (op == OP_MULT) || (op == OP_DIV);

    neg_if #(.W(WIDTH)) u_abs_a (
        .neg  (signed_op & rs_data[WIDTH-1]),
        .din  (rs_data),
        .dout (abs_a)
    );

    neg_if #(.W(WIDTH)) u_abs_b (
        .neg  (signed_op & rt_data[WIDTH-1]),
        .din  (rt_data),
        .dout (abs_b)
    );

    neg_if #(.W(2*WIDTH)) u_neg_prod (
        .neg  (sign),
        .din  (acc),
        .dout (prod_fix)
    );

    neg_if #(.W(WIDTH)) u_neg_quot (
        .neg  (q_sign),
        .din  (op_a),
        .dout (quot_fix)
    );

    neg_if #(.W(WIDTH)) u_neg_rem (
        .neg  (r_sign),
        .din  (acc[WIDTH-1:0]),
        .dout (rem_fix)
    );

    // Multiply: op_a = multiplicand, op_b = multiplier shifting right,
    // product bits enter acc from the top and shift down.
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (op_b[0] ? op_a : '0)};

    // Divide: op_a = dividend shifting out MSB-first / quotient shifting in,
    // op_b = divisor, acc[WIDTH:0] = partial remainder.
    assign rem_sh   = {acc[WIDTH-1:0], op_a[WIDTH-1]};
    assign div_diff = {1'b0, rem_sh} - {2'b00, op_b};

    always_comb begin
        state_nx       = state;
        is_mul_nx      = is_mul;
        sign_nx        = sign;
        q_sign_nx      = q_sign;
        r_sign_nx      = r_sign;
        op_a_nx        = op_a;
        op_b_nx        = op_b;
        acc_nx         = acc;
        cnt_nx         = cnt;
        write_hi_nx    = write_hi;
        write_lo_nx    = write_lo;
        div_by_zero_nx = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start && !flush) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            op_a_nx   = abs_a;
                            op_b_nx   = abs_b;
                            sign_nx   = signed_op & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                            is_mul_nx = 1'b1;
                            acc_nx    = '0;
                            cnt_nx    = '0;
                            state_nx  = ST_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (rt_data == '0) begin
                                write_hi_nx    = rs_data;
                                write_lo_nx    = '1;
                                div_by_zero_nx = 1'b1;
                                state_nx       = ST_WB;
                            end else begin
                                op_a_nx   = abs_a;
                                op_b_nx   = abs_b;
                                q_sign_nx = signed_op & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                                r_sign_nx = signed_op & rs_data[WIDTH-1];
                                is_mul_nx = 1'b0;
                                acc_nx    = '0;
                                cnt_nx    = '0;
                                state_nx  = ST_DIV;
                            end
                        end
                        OP_MTHI: begin
                            write_hi_nx = rs_data;
                            write_lo_nx = lo_cur;
                            state_nx    = ST_WB;
                        end
                        OP_MTLO: begin
                            write_hi_nx = hi_cur;
                            write_lo_nx = rs_data;
                            state_nx    = ST_WB;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                if (flush) begin
                    state_nx = ST_IDLE;
                end else if (cnt == CW'(ITER)) begin
                    state_nx = ST_FIX;
                end else begin
                    acc_nx  = {mul_sum, acc[WIDTH-1:1]};
                    op_b_nx = op_b >> 1;
                    cnt_nx  = cnt + CW'(1);
                end
            end
            ST_DIV: begin
                if (flush) begin
                    state_nx = ST_IDLE;
                end else if (cnt == CW'(ITER)) begin
                    state_nx = ST_FIX;
                end else begin
                    if (!div_diff[WIDTH+1]) begin
                        acc_nx  = {{(WIDTH-1){1'b0}}, div_diff[WIDTH:0]};
                        op_a_nx = {op_a[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_nx  = {{(WIDTH-1){1'b0}}, rem_sh};
                        op_a_nx = {op_a[WIDTH-2:0], 1'b0};
                    end
                    cnt_nx = cnt + CW'(1);
                end
            end
            ST_FIX: begin
                if (flush) begin
                    state_nx = ST_IDLE;
                end else begin
                    if (is_mul) begin
                        write_hi_nx = prod_fix[2*WIDTH-1:WIDTH];
                        write_lo_nx = prod_fix[WIDTH-1:0];
                    end else begin
                        write_hi_nx = rem_fix;
                        write_lo_nx = quot_fix;
                    end
                    state_nx = ST_WB;
                end
            end
            // The write is already on the bus during WB, so flush cannot stop it.
            ST_WB:   state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase

        busy_nx     = (state_nx != ST_IDLE);
        hi_lo_we_nx = (state_nx == ST_WB);
        done_nx     = (state_nx == ST_WB);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            is_mul      <= 1'b0;
            sign        <= 1'b0;
            q_sign      <= 1'b0;
            r_sign      <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
            acc         <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hi_lo_we    <= 1'b0;
            div_by_zero <= 1'b0;
            write_hi    <= '0;
            write_lo    <= '0;
        end else begin
            state       <= state_nx;
            is_mul      <= is_mul_nx;
            sign        <= sign_nx;
            q_sign      <= q_sign_nx;
            r_sign      <= r_sign_nx;
            op_a        <= op_a_nx;
            op_b        <= op_b_nx;
            acc         <= acc_nx;
            cnt         <= cnt_nx;
            busy        <= busy_nx;
            done        <= done_nx;
            hi_lo_we    <= hi_lo_we_nx;
            div_by_zero <= div_by_zero_nx;
            write_hi    <= write_hi_nx;
            write_lo    <= write_lo_nx;
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: latency, arithmetic results, MTHI/MTLO,
// divide-by-zero, ignored ops, and cancellation by flush and reset.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  op;
    logic [31:0] rs_data, rt_data, hi_cur, lo_cur;
    logic        busy, done, hi_lo_we, div_by_zero;
    logic [31:0] write_hi, write_lo;

    int n_checks = 0;
    int n_fail   = 0;

    int          we_cyc, busy_cnt, we_seen;
    logic [31:0] r_hi, r_lo;
    logic        r_dbz, r_done;

    muldiv_seq #(.WIDTH(32), .ITER(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .hi_cur      (hi_cur),
        .lo_cur      (lo_cur),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .hi_lo_we    (hi_lo_we),
        .write_hi    (write_hi),
        .write_lo    (write_lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one op at a negedge and watches up to 45 cycles; cycle i is the
    // i-th negedge after the start edge.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int wc, output int bc, output logic [31:0] hi,
                          output logic [31:0] lo, output logic dbz, output logic dn);
        wc = 0; bc = 0; hi = '0; lo = '0; dbz = 1'b0; dn = 1'b0;
        op = o; rs_data = a; rt_data = b; start = 1'b1;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (busy) bc++;
            if (hi_lo_we && wc == 0) begin
                wc = i; hi = write_hi; lo = write_lo; dbz = div_by_zero; dn = done;
            end
            if (wc != 0 && !busy) break;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0;
        rs_data = '0; rt_data = '0; hi_cur = '0; lo_cur = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",     64'(busy),        64'd0);
        chk("rst_done",     64'(done),        64'd0);
        chk("rst_we",       64'(hi_lo_we),    64'd0);
        chk("rst_dbz",      64'(div_by_zero), 64'd0);
        chk("rst_write_hi", 64'(write_hi),    64'd0);
        chk("rst_write_lo", 64'(write_lo),    64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, we_cyc, busy_cnt, r_hi, r_lo, r_dbz, r_done);
        chk("mult_we_cycle", 64'(we_cyc),   64'd35);
        chk("mult_busy_cnt", 64'(busy_cnt), 64'd35);
        chk("mult_hi",       64'(r_hi),     64'hFFFF_FFFF);
        chk("mult_lo",       64'(r_lo),     64'hFFFF_FFFA);
        chk("mult_done",     64'(r_done),   64'd1);
        chk("mult_dbz",      64'(r_dbz),    64'd0);

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, we_cyc, busy_cnt, r_hi, r_lo, r_dbz, r_done);
        chk("multu_hi", 64'(r_hi), 64'hFFFF_FFFE);
        chk("multu_lo", 64'(r_lo), 64'h0000_0001);

        run_op(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, we_cyc, busy_cnt, r_hi, r_lo, r_dbz, r_done);
        chk("mult_m1_hi", 64'(r_hi), 64'h0);
        chk("mult_m1_lo", 64'(r_lo), 64'h1);

        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, we_cyc, busy_cnt, r_hi, r_lo, r_dbz, r_done);
        chk("div_neg_we_cycle", 64'(we_cyc), 64'd35);
        chk("div_neg_lo",       64'(r_lo),   64'hFFFF_FFFD);
        chk("div_neg_hi",       64'(r_hi),   64'hFFFF_FFFF);
        chk("div_neg_dbz",      64'(r_dbz),  64'd0);

        run_op(OP_DIVU, 32'd7, 32'd2, we_cyc, busy_cnt, r_hi, r_lo, r_dbz, r_done);
        chk("divu_lo", 64'(r_lo), 64'd3);
        chk("divu_hi", 64'(r_hi), 64'd1);

        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, we_cyc, busy_cnt, r_hi, r_lo, r_dbz, r_done);
        chk("div_ovf_lo", 64'(r_lo), 64'h8000_0000);
        chk("div_ovf_hi", 64'(r_hi), 64'h0);

        run_op(OP_DIV, 32'd5, 32'd0, we_cyc, busy_cnt, r_hi, r_lo, r_dbz, r_done);
        chk("dbz_we_cycle", 64'(we_cyc),   64'd1);
        chk("dbz_busy_cnt", 64'(busy_cnt), 64'd1);
        chk("dbz_flag",     64'(r_dbz),    64'd1);
        chk("dbz_done",     64'(r_done),   64'd1);
        chk("dbz_hi",       64'(r_hi),     64'd5);
        chk("dbz_lo",       64'(r_lo),     64'hFFFF_FFFF);

        hi_cur = 32'h0; lo_cur = 32'hAAAA_5555;
        run_op(OP_MTHI, 32'h1234_5678, 32'h0, we_cyc, busy_cnt, r_hi, r_lo, r_dbz, r_done);
        chk("mthi_we_cycle", 64'(we_cyc), 64'd1);
        chk("mthi_hi",       64'(r_hi),   64'h1234_5678);
        chk("mthi_lo",       64'(r_lo),   64'hAAAA_5555);

        hi_cur = 32'hCAFE_F00D; lo_cur = 32'h0;
        run_op(OP_MTLO, 32'h8765_4321, 32'h0, we_cyc, busy_cnt, r_hi, r_lo, r_dbz, r_done);
        chk("mtlo_we_cycle", 64'(we_cyc), 64'd1);
        chk("mtlo_hi",       64'(r_hi),   64'hCAFE_F00D);
        chk("mtlo_lo",       64'(r_lo),   64'h8765_4321);

        run_op(3'd7, 32'h1, 32'h1, we_cyc, busy_cnt, r_hi, r_lo, r_dbz, r_done);
        chk("undef_we_cycle", 64'(we_cyc),   64'd0);
        chk("undef_busy_cnt", 64'(busy_cnt), 64'd0);

        // Flush mid-multiply, with an MTHI attempted while busy.
        we_seen = 0;
        op = OP_MULT; rs_data = 32'd3; rt_data = 32'd5; start = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (i == 5) begin start = 1'b1; op = OP_MTHI; rs_data = 32'hDEAD_BEEF; end
            if (i == 6) start = 1'b0;
            if (hi_lo_we) we_seen++;
        end
        chk("flush_busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy_after", 64'(busy),     64'd0);
        chk("flush_we_after",   64'(hi_lo_we), 64'd0);
        chk("flush_no_we",      64'(we_seen),  64'd0);
        run_op(OP_DIVU, 32'd9, 32'd4, we_cyc, busy_cnt, r_hi, r_lo, r_dbz, r_done);
        chk("flush_divu_we_cycle", 64'(we_cyc), 64'd35);
        chk("flush_divu_lo",       64'(r_lo),   64'd2);
        chk("flush_divu_hi",       64'(r_hi),   64'd1);

        // Same cancellation via reset.
        we_seen = 0;
        op = OP_MULT; rs_data = 32'd7; rt_data = 32'd11; start = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (hi_lo_we) we_seen++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_busy",     64'(busy),     64'd0);
        chk("rst_mid_write_hi", 64'(write_hi), 64'd0);
        chk("rst_mid_no_we",    64'(we_seen),  64'd0);
        run_op(OP_DIVU, 32'd9, 32'd4, we_cyc, busy_cnt, r_hi, r_lo, r_dbz, r_done);
        chk("rst_divu_we_cycle", 64'(we_cyc), 64'd35);
        chk("rst_divu_lo",       64'(r_lo),   64'd2);
        chk("rst_divu_hi",       64'(r_hi),   64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
